// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch port
// (read-only) and the load/store port (read/write). Arbitration is
// round-robin. Only one access is in flight at a time.
//
// Handshake (both requester ports, Avalon style): a requester raises rd/wr
// and keeps it and its address/data stable until the cycle in which its
// waitrequest is 0. That cycle is the accept cycle, and the access is issued
// to memory combinationally in that same cycle. The requester may drop the
// request before it is accepted, which withdraws it. Read data comes back
// RD_LAT cycles later, marked by a one-cycle rddatavalid pulse on the port
// that owns the read.
//
// Parameters
//   IW       address/data width
//   RD_LAT   memory read latency in cycles (>= 1)
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   i_pc_*                 fetch request (addr, rd, byte_en)
//   o_pc_waitrequest       0 only in the fetch accept cycle
//   o_pc_rddata/valid      fetch read data (passthrough) and valid pulse
//   i_ldst_*               load/store request (addr, rd, wr, wrdata, byte_en)
//   o_ldst_waitrequest     0 only in the load/store accept cycle
//   o_ldst_rddata/valid    load data (passthrough) and valid pulse
//   o_mem_*                memory command (addr, rd, wr, wrdata, byte_en)
//   i_mem_rddata           memory read data, valid RD_LAT cycles after rd
//   o_dbg_state            {rr pointer (1 = ldst), fsm state (1 = READ_WAIT)}
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int IW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] i_pc_addr,
  input  logic          i_pc_rd,
  input  logic [3:0]    i_pc_byte_en,
  output logic          o_pc_waitrequest,
  output logic [IW-1:0] o_pc_rddata,
  output logic          o_pc_rddatavalid,
  input  logic [IW-1:0] i_ldst_addr,
  input  logic          i_ldst_rd,
  input  logic          i_ldst_wr,
  input  logic [IW-1:0] i_ldst_wrdata,
  input  logic [3:0]    i_ldst_byte_en,
  output logic          o_ldst_waitrequest,
  output logic [IW-1:0] o_ldst_rddata,
  output logic          o_ldst_rddatavalid,
  output logic [IW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [IW-1:0] o_mem_wrdata,
  output logic [3:0]    o_mem_byte_en,
  input  logic [IW-1:0] i_mem_rddata,
  output logic [1:0]    o_dbg_state
);

  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_READ_WAIT = 1'b1
  } state_t;

  localparam logic SEL_PC   = 1'b0;
  localparam logic SEL_LDST = 1'b1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;

  logic pc_req, ldst_req, can_accept;
  logic grant_pc, grant_ldst, acc_read, data_due;

  // Arbitration. Nothing is granted while reset is high or a read is in
  // flight; on contention the rr pointer decides.
  always_comb begin
    pc_req     = i_pc_rd;
    ldst_req   = i_ldst_rd | i_ldst_wr;
    can_accept = (state_q == S_IDLE) && !reset;
    grant_ldst = can_accept && ldst_req && (!pc_req || (rr_q == SEL_LDST));
    grant_pc   = can_accept && pc_req && !grant_ldst;
    // rd together with wr on the load/store port is treated as a write only.
    acc_read   = grant_pc || (grant_ldst && !i_ldst_wr);
    data_due   = (state_q == S_READ_WAIT) && (cnt_q == CW'(1)) && !reset;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= SEL_PC;
      rr_q    <= SEL_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        // Pointer moves to the side that did not win, on every accept.
        if (grant_pc || grant_ldst) begin
          rr_d = grant_pc ? SEL_LDST : SEL_PC;
        end
        if (acc_read) begin
          state_d = S_READ_WAIT;
          cnt_d   = CW'(RD_LAT);
          owner_d = grant_ldst ? SEL_LDST : SEL_PC;
        end
      end
      S_READ_WAIT: begin
        // cnt_q == 1 is the data-return cycle; the next cycle is IDLE again.
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_pc_waitrequest   = 1'b1;
    o_ldst_waitrequest = 1'b1;
    o_pc_rddatavalid   = 1'b0;
    o_ldst_rddatavalid = 1'b0;
    o_mem_addr         = '0;
    o_mem_rd           = 1'b0;
    o_mem_wr           = 1'b0;
    o_mem_wrdata       = '0;
    o_mem_byte_en      = 4'b0000;

    if (grant_pc) begin
      o_pc_waitrequest = 1'b0;
      o_mem_addr       = i_pc_addr;
      o_mem_byte_en    = i_pc_byte_en;
      o_mem_rd         = 1'b1;
    end else if (grant_ldst) begin
      o_ldst_waitrequest = 1'b0;
      o_mem_addr         = i_ldst_addr;
      o_mem_byte_en      = i_ldst_byte_en;
      if (i_ldst_wr) begin
        o_mem_wr     = 1'b1;
        o_mem_wrdata = i_ldst_wrdata;
      end else begin
        o_mem_rd = 1'b1;
      end
    end

    if (data_due) begin
      o_pc_rddatavalid   = (owner_q == SEL_PC);
      o_ldst_rddatavalid = (owner_q == SEL_LDST);
    end
  end

  assign o_pc_rddata   = i_mem_rddata;
  assign o_ldst_rddata = i_mem_rddata;
  assign o_dbg_state   = {rr_q, logic'(state_q)};

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int IW   = 32;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset;

  // ---------------- main DUT (RD_LAT = 1) ----------------
  logic [IW-1:0] i_pc_addr, o_pc_rddata, i_ldst_addr, i_ldst_wrdata, o_ldst_rddata;
  logic [IW-1:0] o_mem_addr, o_mem_wrdata, i_mem_rddata;
  logic          i_pc_rd, o_pc_waitrequest, o_pc_rddatavalid;
  logic          i_ldst_rd, i_ldst_wr, o_ldst_waitrequest, o_ldst_rddatavalid;
  logic          o_mem_rd, o_mem_wr;
  logic [3:0]    i_pc_byte_en, i_ldst_byte_en, o_mem_byte_en;
  logic [1:0]    o_dbg_state;

  mem_port_arbiter #(.IW(IW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_pc_addr(i_pc_addr), .i_pc_rd(i_pc_rd), .i_pc_byte_en(i_pc_byte_en),
    .o_pc_waitrequest(o_pc_waitrequest), .o_pc_rddata(o_pc_rddata),
    .o_pc_rddatavalid(o_pc_rddatavalid),
    .i_ldst_addr(i_ldst_addr), .i_ldst_rd(i_ldst_rd), .i_ldst_wr(i_ldst_wr),
    .i_ldst_wrdata(i_ldst_wrdata), .i_ldst_byte_en(i_ldst_byte_en),
    .o_ldst_waitrequest(o_ldst_waitrequest), .o_ldst_rddata(o_ldst_rddata),
    .o_ldst_rddatavalid(o_ldst_rddatavalid),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .o_mem_wrdata(o_mem_wrdata), .o_mem_byte_en(o_mem_byte_en),
    .i_mem_rddata(i_mem_rddata), .o_dbg_state(o_dbg_state)
  );

  // ---------------- second DUT (RD_LAT = 3) ----------------
  logic [IW-1:0] pc_addr_3, pc_rddata_3, ldst_addr_3, ldst_wrdata_3, ldst_rddata_3;
  logic [IW-1:0] mem_addr_3, mem_wrdata_3, mem_rddata_3;
  logic          reset_3, pc_rd_3, pc_wait_3, pc_valid_3;
  logic          ldst_rd_3, ldst_wr_3, ldst_wait_3, ldst_valid_3, mem_rd_3, mem_wr_3;
  logic [3:0]    pc_be_3, ldst_be_3, mem_be_3;
  logic [1:0]    dbg_3;

  mem_port_arbiter #(.IW(IW), .RD_LAT(LAT3)) dut3 (
    .clk(clk), .reset(reset_3),
    .i_pc_addr(pc_addr_3), .i_pc_rd(pc_rd_3), .i_pc_byte_en(pc_be_3),
    .o_pc_waitrequest(pc_wait_3), .o_pc_rddata(pc_rddata_3),
    .o_pc_rddatavalid(pc_valid_3),
    .i_ldst_addr(ldst_addr_3), .i_ldst_rd(ldst_rd_3), .i_ldst_wr(ldst_wr_3),
    .i_ldst_wrdata(ldst_wrdata_3), .i_ldst_byte_en(ldst_be_3),
    .o_ldst_waitrequest(ldst_wait_3), .o_ldst_rddata(ldst_rddata_3),
    .o_ldst_rddatavalid(ldst_valid_3),
    .o_mem_addr(mem_addr_3), .o_mem_rd(mem_rd_3), .o_mem_wr(mem_wr_3),
    .o_mem_wrdata(mem_wrdata_3), .o_mem_byte_en(mem_be_3),
    .i_mem_rddata(mem_rddata_3), .o_dbg_state(dbg_3)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0050_0093;          // word at 0x10
    return 32'hA500_0000 ^ (i * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_d;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
    return r;
  endfunction

  // ---------------- memory model behind the main DUT ----------------
  logic [31:0] mem_arr [0:255];
  logic [31:0] pipe [0:LAT-1];
  initial begin
    logic        m_rd, m_wr;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_be;
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    for (int i = 0; i < LAT; i++) pipe[i] = 32'hDEAD_0000;
    i_mem_rddata = pipe[LAT-1];
    forever begin
      @(negedge clk);
      m_rd = o_mem_rd; m_wr = o_mem_wr; m_addr = o_mem_addr;
      m_data = o_mem_wrdata; m_be = o_mem_byte_en;
      @(posedge clk);
      if (m_wr) mem_arr[m_addr[9:2]] = merge(mem_arr[m_addr[9:2]], m_data, m_be);
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = m_rd ? mem_arr[m_addr[9:2]] : (32'hDEAD_0000 ^ cyc);
      i_mem_rddata = pipe[LAT-1];
    end
  end

  // ---------------- driver: command queues per requester ----------------
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  cmd_t pc_cmd_q[$];
  cmd_t ldst_cmd_q[$];
  logic pc_acc = 1'b0;
  logic ldst_acc = 1'b0;

  task automatic push_pc(input logic [31:0] addr, input logic [3:0] be);
    pc_cmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: addr, data: 32'h0, be: be});
  endtask

  task automatic push_ldst(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    ldst_cmd_q.push_back('{rd: rd, wr: wr, addr: addr, data: data, be: be});
  endtask

  task automatic drive_heads();
    if (pc_cmd_q.size() > 0) begin
      i_pc_rd = 1'b1; i_pc_addr = pc_cmd_q[0].addr; i_pc_byte_en = pc_cmd_q[0].be;
    end else begin
      i_pc_rd = 1'b0; i_pc_addr = $urandom; i_pc_byte_en = 4'h0;
    end
    if (ldst_cmd_q.size() > 0) begin
      i_ldst_rd = ldst_cmd_q[0].rd; i_ldst_wr = ldst_cmd_q[0].wr;
      i_ldst_addr = ldst_cmd_q[0].addr; i_ldst_wrdata = ldst_cmd_q[0].data;
      i_ldst_byte_en = ldst_cmd_q[0].be;
    end else begin
      i_ldst_rd = 1'b0; i_ldst_wr = 1'b0; i_ldst_addr = $urandom;
      i_ldst_wrdata = $urandom; i_ldst_byte_en = 4'h0;
    end
  endtask

  initial begin
    drive_heads();
    forever begin
      @(posedge clk);
      if (pc_acc && pc_cmd_q.size() > 0) void'(pc_cmd_q.pop_front());
      if (ldst_acc && ldst_cmd_q.size() > 0) void'(ldst_cmd_q.pop_front());
      #1;
      drive_heads();
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] ref_mem [0:255];
  logic [31:0] pc_exp_q[$];
  logic [31:0] ldst_exp_q[$];
  int          pc_cyc_q[$];
  int          ldst_cyc_q[$];
  logic [31:0] exp_grant_q[$];     // 0 = pc, 1 = ldst
  int          grant_cyc_q[$];

  task automatic note_grant(input logic [31:0] who);
    grant_cyc_q.push_back(cyc);
    if (exp_grant_q.size() > 0) check_val("grant_order", who, exp_grant_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      pc_acc   = i_pc_rd && !o_pc_waitrequest;
      ldst_acc = (i_ldst_rd || i_ldst_wr) && !o_ldst_waitrequest;
      if (pc_acc || ldst_acc) check_val("one_grant", 32'(pc_acc && ldst_acc), 0);
      if (pc_acc) begin
        check_val("pc_mem_strobes", {o_mem_rd, o_mem_wr}, 2'b10);
        check_val("pc_mem_addr", o_mem_addr, i_pc_addr);
        check_val("pc_mem_be", o_mem_byte_en, i_pc_byte_en);
        pc_exp_q.push_back(ref_mem[i_pc_addr[9:2]]);
        pc_cyc_q.push_back(cyc);
        note_grant(0);
      end else if (ldst_acc) begin
        check_val("ldst_mem_addr", o_mem_addr, i_ldst_addr);
        check_val("ldst_mem_be", o_mem_byte_en, i_ldst_byte_en);
        if (i_ldst_wr) begin
          check_val("wr_mem_strobes", {o_mem_rd, o_mem_wr}, 2'b01);
          check_val("wr_mem_data", o_mem_wrdata, i_ldst_wrdata);
          ref_mem[i_ldst_addr[9:2]] = merge(ref_mem[i_ldst_addr[9:2]], i_ldst_wrdata,
                                            i_ldst_byte_en);
        end else begin
          check_val("rd_mem_strobes", {o_mem_rd, o_mem_wr}, 2'b10);
          ldst_exp_q.push_back(ref_mem[i_ldst_addr[9:2]]);
          ldst_cyc_q.push_back(cyc);
        end
        note_grant(1);
      end else begin
        check_val("idle_strobes", {o_mem_rd, o_mem_wr}, 2'b00);
        check_val("idle_mem_addr", o_mem_addr, 0);
      end
      if (o_pc_rddatavalid) begin
        if (pc_exp_q.size() == 0) check_val("pc_unexpected_valid", 32'(o_pc_rddatavalid), 0);
        else begin
          check_val("pc_rddata", o_pc_rddata, pc_exp_q.pop_front());
          check_val("pc_latency", cyc - pc_cyc_q.pop_front(), LAT);
        end
      end
      if (o_ldst_rddatavalid) begin
        if (ldst_exp_q.size() == 0) check_val("ldst_unexpected_valid", 32'(o_ldst_rddatavalid), 0);
        else begin
          check_val("ldst_rddata", o_ldst_rddata, ldst_exp_q.pop_front());
          check_val("ldst_latency", cyc - ldst_cyc_q.pop_front(), LAT);
        end
      end
    end
  end

  function automatic int pending();
    return pc_cmd_q.size() + ldst_cmd_q.size() + pc_exp_q.size() + ldst_exp_q.size()
           + exp_grant_q.size();
  endfunction

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while (pending() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check_val(tag, pending(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int base;
    logic [31:0] a;
    reset = 1'b1;
    reset_3 = 1'b1; pc_rd_3 = 1'b0; pc_addr_3 = '0; pc_be_3 = 4'hF;
    ldst_addr_3 = '0; ldst_rd_3 = 1'b0; ldst_wr_3 = 1'b0; ldst_wrdata_3 = '0;
    ldst_be_3 = 4'h0; mem_rddata_3 = 32'hCAFE_0003;

    // 1 + 3: both ports request through reset, then contend after release
    push_pc(32'h20, 4'hF);
    push_ldst(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    repeat (3) begin
      @(negedge clk);
      check_val("rst_mem_rd", o_mem_rd, 0);
      check_val("rst_waitreqs", {o_pc_waitrequest, o_ldst_waitrequest}, 2'b11);
      check_val("rst_valids", {o_pc_rddatavalid, o_ldst_rddatavalid}, 2'b00);
      check_val("rst_dbg_state", o_dbg_state, 2'b00);
    end
    base = grant_cyc_q.size();
    @(posedge clk); #1 reset = 1'b0;
    drain("contention_drain", 50);
    check_val("contention_grants", grant_cyc_q.size() - base, 2);
    if (grant_cyc_q.size() - base >= 2)
      check_val("contention_spacing", grant_cyc_q[base+1] - grant_cyc_q[base], LAT + 1);

    // 2: fetch only, data 0x00500093 at 0x10
    push_pc(32'h10, 4'hF);
    exp_grant_q.push_back(0);
    drain("fetch_drain", 30);

    // 4: back-to-back stores, last one with rd and wr both set
    base = grant_cyc_q.size();
    push_ldst(1'b0, 1'b1, 32'h200, 32'hA, 4'b0001);
    push_ldst(1'b0, 1'b1, 32'h204, 32'hB, 4'b0011);
    push_ldst(1'b0, 1'b1, 32'h208, 32'hC, 4'b1111);
    push_ldst(1'b1, 1'b1, 32'h20C, 32'hD, 4'b1111);
    repeat (4) exp_grant_q.push_back(1);
    drain("store_drain", 30);
    check_val("store_grants", grant_cyc_q.size() - base, 4);
    if (grant_cyc_q.size() - base >= 4)
      for (int i = 1; i < 4; i++)
        check_val("store_back_to_back", grant_cyc_q[base+i] - grant_cyc_q[base+i-1], 1);
    // read the stored words back through the arbiter
    push_ldst(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    push_ldst(1'b1, 1'b0, 32'h204, 32'h0, 4'hF);
    push_ldst(1'b1, 1'b0, 32'h20C, 32'h0, 4'hF);
    repeat (3) exp_grant_q.push_back(1);
    drain("readback_drain", 30);

    // 5: fairness, both ports busy for 20 accesses; rr pointer is at pc now
    for (int i = 0; i < 10; i++) begin
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      push_pc(a, 4'($urandom_range(1, 15)));
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 1) == 1)
        push_ldst(1'b0, 1'b1, a, $urandom, 4'($urandom_range(1, 15)));
      else
        push_ldst(1'b1, 1'b0, a, 32'h0, 4'($urandom_range(1, 15)));
      exp_grant_q.push_back(0);
      exp_grant_q.push_back(1);
    end
    drain("fair_drain", 200);

    // 6: RD_LAT = 3 instance, full read then reset in the middle of a read
    @(posedge clk); #1 reset_3 = 1'b0; pc_rd_3 = 1'b1; pc_addr_3 = 32'h40;
    @(negedge clk);
    check_val("l3_accept", {pc_wait_3, mem_rd_3}, 2'b01);
    check_val("l3_mem_addr", mem_addr_3, 32'h40);
    @(posedge clk); #1 pc_rd_3 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_val("l3_pc_valid", pc_valid_3, (k == LAT3) ? 1 : 0);
      check_val("l3_ldst_valid", ldst_valid_3, 0);
      if (k == LAT3) check_val("l3_rddata", pc_rddata_3, 32'hCAFE_0003);
    end
    check_val("l3_dbg_after_read", dbg_3, 2'b10);
    @(posedge clk); #1 pc_rd_3 = 1'b1; pc_addr_3 = 32'h44;
    @(negedge clk);
    check_val("l3_accept2", pc_wait_3, 0);
    @(posedge clk); #1 pc_rd_3 = 1'b0; reset_3 = 1'b1;
    @(negedge clk);
    check_val("l3_rst_waitreqs", {pc_wait_3, ldst_wait_3}, 2'b11);
    @(posedge clk); #1 reset_3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("l3_no_valid_after_reset", {pc_valid_3, ldst_valid_3}, 2'b00);
      check_val("l3_dbg_after_reset", dbg_3, 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
